array_8_rw_arbiter: RTL and testbench

Arbiter and sequencer for the 2-entry x 72-bit single-port RW SRAM macro used in the frontend/backend metadata arrays. It shares the single RW port between one read requester and one write requester. Writes are posted through a 1-entry write buffer, and reads that hit the pending write are bypassed. After reset it zero-initialises the array before opening either requester port. The block sits directly between the requesting pipeline stage and the SRAM macro's RW0 pins.

---
 rtl/array_ctrl_pkg.sv | 19 +
 rtl/array_ctrl_wbuf.sv | 64 ++++++
 rtl/array_8_rw_arbiter.sv | 151 +++++++++++++++
 tb/tb_array_8_rw_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// array_ctrl_pkg : shared types and defaults for the 2x72 metadata array family
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package array_ctrl_pkg;

  localparam int unsigned ARR_DATA_W = 72;
  localparam int unsigned ARR_ADDR_W = 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arr_state_e;

endpackage

`default_nettype wire

// File: rtl/array_ctrl_wbuf.sv
// ----------------------------------------------------------------------------
// array_ctrl_wbuf : single-entry posted write buffer with read-hit compare
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module array_ctrl_wbuf
  import array_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = ARR_DATA_W,
  parameter int unsigned ADDR_W = ARR_ADDR_W
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              hit_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Load wins over drain so a write can refill the entry in its drain cycle.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (drain_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign hit_o   = valid_q && (r_addr_i == addr_q);

endmodule

`default_nettype wire

// File: rtl/array_8_rw_arbiter.sv
// ----------------------------------------------------------------------------
// array_8_rw_arbiter : read/write arbiter and zero-init sequencer for a 1RW SRAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module array_8_rw_arbiter
  import array_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W          = ARR_DATA_W,
  parameter int unsigned ADDR_W          = ARR_ADDR_W,
  parameter int unsigned MAX_READ_STREAK = 4,
  parameter bit          INIT_ZERO       = 1'b1
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_data_o,
  input  logic              w_valid_i,
  output logic              w_ready_o,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              init_done_o,
  output logic              sram_en_o,
  output logic              sram_wmode_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i
);

  localparam int unsigned         STREAK_W    = $clog2(MAX_READ_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_READ_STREAK);
  localparam logic [ADDR_W-1:0]   LAST_ADDR   = {ADDR_W{1'b1}};
  localparam arr_state_e          RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

  arr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                resp_valid_q, byp_q;
  logic [DATA_W-1:0]   byp_data_q;

  logic                wb_valid, wb_hit;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;

  logic run, rd_hit, rd_miss, rd_acc, rd_grant, drain, wr_acc;

  assign run      = (state_q == ST_RUN);
  assign rd_hit   = r_valid_i && wb_hit;
  assign rd_miss  = r_valid_i && !wb_hit;
  assign r_ready_o = run && !(wb_valid && (streak_q == STREAK_MAX) && rd_miss);
  assign rd_acc   = r_valid_i && r_ready_o;
  // A granted miss owns the port; every other RUN cycle may drain the buffer.
  assign rd_grant = rd_acc && rd_miss;
  assign drain    = run && wb_valid && !rd_grant;
  assign w_ready_o = run && (!wb_valid || drain);
  assign wr_acc   = w_valid_i && w_ready_o;

  array_ctrl_wbuf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wbuf (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .load_i    (wr_acc),
    .drain_i   (drain),
    .addr_i    (w_addr_i),
    .data_i    (w_data_i),
    .r_addr_i  (r_addr_i),
    .valid_o   (wb_valid),
    .addr_o    (wb_addr),
    .data_o    (wb_data),
    .hit_o     (wb_hit)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= RESET_STATE;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    sram_en_o    = 1'b0;
    sram_wmode_o = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (state_q == ST_INIT) begin
      sram_en_o    = 1'b1;
      sram_wmode_o = 1'b1;
      sram_addr_o  = init_cnt_q;
    end else if (rd_grant) begin
      sram_en_o    = 1'b1;
      sram_addr_o  = r_addr_i;
    end else if (drain) begin
      sram_en_o    = 1'b1;
      sram_wmode_o = 1'b1;
      sram_addr_o  = wb_addr;
      sram_wdata_o = wb_data;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!wb_valid || drain) begin
      streak_d = '0;
    end else if (rd_grant) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      streak_q     <= '0;
      resp_valid_q <= 1'b0;
      byp_q        <= 1'b0;
      byp_data_q   <= '0;
    end else begin
      streak_q     <= streak_d;
      resp_valid_q <= rd_acc;
      byp_q        <= rd_hit && rd_acc;
      if (rd_hit && rd_acc) begin
        byp_data_q <= wb_data;
      end
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = byp_q ? byp_data_q : sram_rdata_i;
  assign init_done_o  = run;

endmodule

`default_nettype wire

// File: tb/tb_array_8_rw_arbiter.sv
// ----------------------------------------------------------------------------
// tb_array_8_rw_arbiter : self-checking bench with a logical-array reference
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_array_8_rw_arbiter;

  localparam int DATA_W = 72;
  localparam int ADDR_W = 1;
  localparam int MAXS   = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              r_valid, r_ready, resp_valid, w_valid, w_ready, init_done;
  logic [ADDR_W-1:0] r_addr, w_addr, sram_addr;
  logic [DATA_W-1:0] resp_data, w_data, sram_wdata, sram_rdata;
  logic              sram_en, sram_wmode;

  int checks   = 0;
  int failures = 0;

  // Logical array contents as seen by requesters, in acceptance order.
  logic [DATA_W-1:0] ref_mem [2];
  // Behavioural SRAM macro.
  logic [DATA_W-1:0] mem [2];

  logic              racc, wacc, snap_rr, snap_wr, snap_en, snap_wm;
  logic [ADDR_W-1:0] snap_addr;
  logic [DATA_W-1:0] snap_wdata, exp_rd;

  always #5 clock = ~clock;

  array_8_rw_arbiter #(
    .DATA_W          (DATA_W),
    .ADDR_W          (ADDR_W),
    .MAX_READ_STREAK (MAXS),
    .INIT_ZERO       (1'b1)
  ) dut (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .r_valid_i    (r_valid),
    .r_ready_o    (r_ready),
    .r_addr_i     (r_addr),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .w_valid_i    (w_valid),
    .w_ready_o    (w_ready),
    .w_addr_i     (w_addr),
    .w_data_i     (w_data),
    .init_done_o  (init_done),
    .sram_en_o    (sram_en),
    .sram_wmode_o (sram_wmode),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata)
  );

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  function automatic logic [DATA_W-1:0] rand_data();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  task automatic drive(input logic rv, input logic [ADDR_W-1:0] ra, input logic wv,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    @(negedge clock);
    r_valid = rv; r_addr = ra; w_valid = wv; w_addr = wa; w_data = wd;
    #1;
    snap_rr = r_ready; snap_wr = w_ready; snap_en = sram_en; snap_wm = sram_wmode;
    snap_addr = sram_addr; snap_wdata = sram_wdata;
    racc = rv && r_ready;
    wacc = wv && w_ready;
    if (racc) exp_rd = ref_mem[ra];
    if (wacc) ref_mem[wa] = wd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; r_valid = 1'b0; w_valid = 1'b0; r_addr = '0; w_addr = '0; w_data = '0;
    mem[0] = rand_data(); mem[1] = rand_data(); sram_rdata = rand_data();
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    checks++; if ({resp_valid, init_done, r_ready, w_ready} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs: got %b expected 0000", {resp_valid, init_done, r_ready, w_ready});
    end
    @(negedge clock);
    reset_n = 1'b1; r_valid = 1'b1; w_valid = 1'b1; r_addr = 1'b1; w_addr = 1'b1; w_data = 72'hDEAD;
    #1;
    checks++; if ({sram_en, sram_wmode, sram_addr} !== 3'b110 || sram_wdata !== 72'h0) begin
      failures++; $display("FAIL init_addr0: got en/wm/addr=%b wdata=%h expected 110 / 0", {sram_en, sram_wmode, sram_addr}, sram_wdata);
    end
    checks++; if ({init_done, r_ready, w_ready} !== 3'b000) begin
      failures++; $display("FAIL init_gating0: got %b expected 000", {init_done, r_ready, w_ready});
    end
    @(negedge clock); #1;
    checks++; if ({sram_en, sram_wmode, sram_addr} !== 3'b111 || sram_wdata !== 72'h0 || {init_done, r_ready, w_ready} !== 3'b000) begin
      failures++; $display("FAIL init_addr1: got en/wm/addr=%b wdata=%h rdy=%b expected 111 / 0 / 000", {sram_en, sram_wmode, sram_addr}, sram_wdata, {init_done, r_ready, w_ready});
    end
    @(negedge clock);
    r_valid = 1'b0; w_valid = 1'b0;
    #1;
    checks++; if ({init_done, r_ready, w_ready, sram_en} !== 4'b1110) begin
      failures++; $display("FAIL init_done: got done/rr/wr/en=%b expected 1110", {init_done, r_ready, w_ready, sram_en});
    end
    ref_mem[0] = '0; ref_mem[1] = '0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 72'h0) begin
      failures++; $display("FAIL init_read1: got v=%b d=%h expected 1 / 0", resp_valid, resp_data);
    end
  endtask

  task automatic test_basic();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 72'hA5);
    tick();
    checks++; if (wacc !== 1'b1 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL basic_wr_accept: got wacc=%b resp_valid=%b expected 1 / 0", wacc, resp_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checks++; if ({snap_en, snap_wm, snap_addr} !== 3'b110 || snap_wdata !== 72'hA5) begin
      failures++; $display("FAIL basic_drain: got en/wm/addr=%b wdata=%h expected 110 / a5", {snap_en, snap_wm, snap_addr}, snap_wdata);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checks++; if ({snap_rr, snap_en, snap_wm} !== 3'b110) begin
      failures++; $display("FAIL basic_sram_read: got rr/en/wm=%b expected 110", {snap_rr, snap_en, snap_wm});
    end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 72'hA5) begin
      failures++; $display("FAIL basic_resp: got v=%b d=%h expected 1 / a5", resp_valid, resp_data);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checks++; if (resp_valid !== 1'b0) begin
      failures++; $display("FAIL basic_resp_single: got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_bypass();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 72'h1234);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    checks++; if ({snap_rr, snap_en, snap_wm, snap_addr} !== 4'b1111 || snap_wdata !== 72'h1234) begin
      failures++; $display("FAIL bypass_drain: got rr/en/wm/addr=%b wdata=%h expected 1111 / 1234", {snap_rr, snap_en, snap_wm, snap_addr}, snap_wdata);
    end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 72'h1234) begin
      failures++; $display("FAIL bypass_resp: got v=%b d=%h expected 1 / 1234", resp_valid, resp_data);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checks++; if (mem[1] !== 72'h1234) begin
      failures++; $display("FAIL bypass_array: got %h expected 1234", mem[1]);
    end
  endtask

  task automatic test_starvation();
    logic [DATA_W-1:0] wd;
    wd = rand_data();
    drive(1'b0, 1'b0, 1'b1, 1'b0, wd);
    tick();
    for (int k = 1; k <= MAXS + 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      checks++; if (snap_rr !== (k != MAXS + 1) || snap_en !== 1'b1 || snap_wm !== (k == MAXS + 1)) begin
        failures++; $display("FAIL starve_cycle%0d: got rr/en/wm=%b%b%b expected %b1%b", k, snap_rr, snap_en, snap_wm, (k != MAXS + 1), (k == MAXS + 1));
      end
      tick();
      checks++; if (resp_valid !== racc || (racc && resp_data !== exp_rd)) begin
        failures++; $display("FAIL starve_resp%0d: got v=%b d=%h expected %b / %h", k, resp_valid, resp_data, racc, exp_rd);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checks++; if (mem[0] !== wd) begin
      failures++; $display("FAIL starve_array: got %h expected %h", mem[0], wd);
    end
  endtask

  task automatic test_same_cycle();
    logic [DATA_W-1:0] old;
    old = ref_mem[0];
    drive(1'b1, 1'b0, 1'b1, 1'b0, 72'hFF);
    checks++; if ({snap_rr, snap_wr, snap_en, snap_wm} !== 4'b1110) begin
      failures++; $display("FAIL same_grant: got rr/wr/en/wm=%b expected 1110", {snap_rr, snap_wr, snap_en, snap_wm});
    end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_data !== old) begin
      failures++; $display("FAIL same_old: got v=%b d=%h expected 1 / %h", resp_valid, resp_data, old);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 72'hFF) begin
      failures++; $display("FAIL same_new_byp: got v=%b d=%h expected 1 / ff", resp_valid, resp_data);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 72'hFF) begin
      failures++; $display("FAIL same_new_sram: got v=%b d=%h expected 1 / ff", resp_valid, resp_data);
    end
  endtask

  task automatic test_random();
    logic prev_stall;
    prev_stall = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 3) != 0, ($urandom % 2) == 1, ($urandom % 2) == 1, ($urandom % 2) == 1, rand_data());
      if (prev_stall) begin
        checks++; if (snap_rr !== 1'b1) begin
          failures++; $display("FAIL rand_stall_bound%0d: got r_ready=%b expected 1", i, snap_rr);
        end
      end
      prev_stall = r_valid && !snap_rr;
      tick();
      checks++; if (resp_valid !== racc || (racc && resp_data !== exp_rd)) begin
        failures++; $display("FAIL rand_resp%0d: got v=%b d=%h expected %b / %h", i, resp_valid, resp_data, racc, exp_rd);
      end
    end
    for (int a = 0; a < 2; a++) begin
      drive(1'b1, a[0], 1'b0, 1'b0, '0);
      tick();
      checks++; if (resp_valid !== racc || (racc && resp_data !== exp_rd)) begin
        failures++; $display("FAIL rand_final%0d: got v=%b d=%h expected %b / %h", a, resp_valid, resp_data, racc, exp_rd);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 72'hBEEF);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    checks++; if (resp_valid !== 1'b1) begin
      failures++; $display("FAIL midrst_inflight: got %b expected 1", resp_valid);
    end
    reset_n = 1'b0; r_valid = 1'b0;
    #1;
    checks++; if ({resp_valid, init_done, r_ready, w_ready} !== 4'b0000) begin
      failures++; $display("FAIL midrst_clear: got %b expected 0000", {resp_valid, init_done, r_ready, w_ready});
    end
    ref_mem[0] = '0; ref_mem[1] = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++; if ({sram_en, sram_wmode, sram_addr, init_done} !== 4'b1100) begin
      failures++; $display("FAIL midrst_init0: got en/wm/addr/done=%b expected 1100", {sram_en, sram_wmode, sram_addr, init_done});
    end
    @(negedge clock); #1;
    checks++; if ({sram_en, sram_wmode, sram_addr, init_done} !== 4'b1110) begin
      failures++; $display("FAIL midrst_init1: got en/wm/addr/done=%b expected 1110", {sram_en, sram_wmode, sram_addr, init_done});
    end
    for (int a = 0; a < 2; a++) begin
      drive(1'b1, a[0], 1'b0, 1'b0, '0);
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_data !== 72'h0) begin
        failures++; $display("FAIL midrst_read%0d: got v=%b d=%h expected 1 / 0", a, resp_valid, resp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_starvation();
    test_same_cycle();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
